booth_mult32: RTL and testbench



---
 rtl/booth_mult32.sv | 107 ++++++++++
 tb/tb_booth_mult32.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/booth_mult32.sv
// Sequential signed WIDTH x WIDTH radix-2 Booth multiplier.
// One iteration per clock: conditional add/sub of the multiplicand into a
// WIDTH+1 bit accumulator, then a 1-bit arithmetic right shift of {hi,lo,q_1}.
// Returns the low WIDTH bits of the product and flags signed overflow.
//
// Handshake: ctrl_start is sampled on every rising edge (no ready back);
// a sampled start in any state loads fresh operands. data_resultRDY is a
// one-cycle valid pulse for data_result/data_exception, which then hold
// until the next completion or reset. busy is high only while iterating.
module booth_mult32 #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_start,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   m;        // sign-extended multiplicand
  logic [WIDTH:0]   hi;       // accumulator, one guard bit so add/sub never wraps
  logic [WIDTH-1:0] lo;       // multiplier, shifted out as product bits shift in
  logic             q_1;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   hi_next;
  logic [WIDTH-1:0] lo_next;
  logic             last_iter;

  assign last_iter      = (state == RUN) && (count == LAST);
  assign data_resultRDY = (state == DONE);
  assign busy           = (state == RUN);

  // Booth step: decode {lo[0],q_1}, add/sub, then arithmetic shift right by one
  always_comb begin
    sum = hi;
    case ({lo[0], q_1})
      2'b01:   sum = hi + m;
      2'b10:   sum = hi - m;
      default: sum = hi;
    endcase
    hi_next = {sum[WIDTH], sum[WIDTH:1]};
    lo_next = {sum[0], lo[WIDTH-1:1]};
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; a start restarts the operation from any state
  always_comb begin
    state_next = state;
    if (ctrl_start) begin
      state_next = RUN;
    end else begin
      case (state)
        IDLE:    state_next = IDLE;
        RUN:     state_next = last_iter ? DONE : RUN;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Datapath: operand load, iteration, and result capture on the final step
  always_ff @(posedge clock) begin
    if (reset) begin
      count          <= '0;
      m              <= '0;
      hi             <= '0;
      lo             <= '0;
      q_1            <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (ctrl_start) begin
      count <= '0;
      m     <= {data_operandA[WIDTH-1], data_operandA};
      hi    <= '0;
      lo    <= data_operandB;
      q_1   <= 1'b0;
    end else if (state == RUN) begin
      hi    <= hi_next;
      lo    <= lo_next;
      q_1   <= lo[0];
      count <= count + 1'b1;
      if (last_iter) begin
        data_result    <= lo_next;
        // overflow when the upper half is not a pure sign extension of the low half
        data_exception <= (hi_next[WIDTH-1:0] != {WIDTH{lo_next[WIDTH-1]}});
      end
    end
  end

endmodule

// File: tb/tb_booth_mult32.sv
// Directed and random checks for booth_mult32.
module tb_booth_mult32;

  logic        clock;
  logic        reset;
  logic        ctrl_start;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int total = 0;
  int bad   = 0;

  booth_mult32 #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_start     (ctrl_start),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // drive a start for one edge; returns #1 after the start edge
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    ctrl_start    = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock); #1;
    ctrl_start    = 1'b0;
    data_operandA = $urandom;   // later operand changes must not matter
    data_operandB = $urandom;
  endtask

  // from #1 after a start edge, count edges until RDY (bounded)
  task automatic wait_done(output int n, output int busy_cnt);
    n = 0;
    busy_cnt = 0;
    while (n < 40) begin
      if (busy) busy_cnt++;
      if (data_resultRDY) break;
      @(posedge clock); #1;
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input logic exp_e);
    int n, bc;
    issue(a, b);
    wait_done(n, bc);
    check({tag, "_lat"}, 64'(n), 64'd32);
    check({tag, "_busy"}, 64'(bc), 64'd32);
    check({tag, "_res"}, 64'(data_result), 64'(exp_r));
    check({tag, "_exc"}, 64'(data_exception), 64'(exp_e));
    @(posedge clock); #1;
    check({tag, "_pulse"}, 64'({data_resultRDY, busy}), 64'd0);
  endtask

  initial begin
    int n, bc;
    logic [31:0] ra, rb;
    longint pa, pb, p, plo;
    logic [63:0] pv;

    reset = 1'b1;
    ctrl_start = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_out", {data_result, data_exception, data_resultRDY, busy}, 64'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // basic, signs, overflow boundaries
    run_op("basic", 32'd3, 32'd4, 32'h0000000C, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    check("hold_res", 64'(data_result), 64'h0000000C);
    run_op("neg_pos", 32'hFFFFFFFB, 32'd7, 32'hFFFFFFDD, 1'b0);
    run_op("neg_neg", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0);
    run_op("max_one", 32'h7FFFFFFF, 32'd1, 32'h7FFFFFFF, 1'b0);
    run_op("min_m1", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
    run_op("big_sq", 32'h00010000, 32'h00010000, 32'h00000000, 1'b1);
    run_op("min_one", 32'h80000000, 32'd1, 32'h80000000, 1'b0);
    run_op("zero", 32'h0, 32'h80000000, 32'h0, 1'b0);

    // restart while running
    issue(32'd3, 32'd4);
    n = 0;
    repeat (9) begin
      if (data_resultRDY) n++;
      @(posedge clock); #1;
    end
    check("rst_early_rdy", 64'(n), 64'd0);
    issue(32'd6, 32'd7);
    wait_done(n, bc);
    check("restart_lat", 64'(n), 64'd32);
    check("restart_res", 64'(data_result), 64'h2A);
    @(posedge clock); #1;
    check("restart_pulse", 64'(data_resultRDY), 64'd0);

    // back-to-back: new start in the DONE cycle
    issue(32'hFFFFFFFB, 32'd7);
    wait_done(n, bc);
    check("b2b_first_lat", 64'(n), 64'd32);
    check("b2b_first_res", 64'(data_result), 64'hFFFFFFDD);
    issue(32'd2, 32'hFFFFFFFD);
    check("b2b_run", 64'({data_resultRDY, busy}), 64'b01);
    check("b2b_hold", 64'(data_result), 64'hFFFFFFDD);
    wait_done(n, bc);
    check("b2b_second_lat", 64'(n), 64'd32);
    check("b2b_second_res", 64'(data_result), 64'hFFFFFFFA);
    check("b2b_second_exc", 64'(data_exception), 64'd0);
    @(posedge clock); #1;

    // reset mid-operation
    issue(32'd9, 32'd9);
    repeat (14) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("midrst_out", {data_result, data_exception, data_resultRDY, busy}, 64'd0);
    n = 0;
    repeat (30) begin
      if (data_resultRDY || busy) n++;
      @(posedge clock); #1;
    end
    check("midrst_quiet", 64'(n), 64'd0);
    run_op("after_rst", 32'd9, 32'd9, 32'd81, 1'b0);

    // random sweep against a 64-bit reference
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 1) == 0) ra = {{16{ra[15]}}, ra[15:0]};
      if ($urandom_range(0, 1) == 0) rb = {{16{rb[15]}}, rb[15:0]};
      pa  = longint'($signed(ra));
      pb  = longint'($signed(rb));
      p   = pa * pb;
      pv  = p;
      plo = longint'($signed(pv[31:0]));
      issue(ra, rb);
      wait_done(n, bc);
      check("rnd_lat", 64'(n), 64'd32);
      check("rnd_res", 64'(data_result), 64'(pv[31:0]));
      check("rnd_exc", 64'(data_exception), 64'(p != plo));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
